i2s2_axil_responder: RTL and testbench

AXI4-Lite slave (responder) register block for the i2s2 IP. It terminates the S00_AXI port driven by the AXI VIP master in the block-design bench. It exposes four 32-bit registers: control, TX sample push, RX sample readback and status. It bridges them to the I2S transmit sample stream (through a small TX FIFO) and the receive sample stream.

---
 rtl/i2s2_axil_pkg.sv | 26 ++
 rtl/i2s2_sync_fifo.sv | 52 +++++
 rtl/i2s2_axil_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_i2s2_axil_responder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s2_axil_pkg.sv
// Shared definitions for the i2s2 AXI4-Lite responder: register offsets,
// response codes, FSM state types and STATUS bit positions.
package i2s2_axil_pkg;

  localparam logic [3:0] CTRL_OFF   = 4'h0;
  localparam logic [3:0] TXDATA_OFF = 4'h4;
  localparam logic [3:0] RXDATA_OFF = 4'h8;
  localparam logic [3:0] STATUS_OFF = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  localparam int ST_RX_NEW    = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_TX_EMPTY  = 2;
  localparam int ST_TX_OVF    = 3;
  localparam int ST_RX_OVF    = 4;
  localparam int ST_LEVEL_LSB = 8;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/i2s2_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO succeeds
// when a pop happens in the same cycle. Flush empties it and overrides push/pop.
module i2s2_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; entries are only read once the
  // pointers say they were written, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/i2s2_axil_responder.sv
// AXI4-Lite register block for i2s2: CTRL, TXDATA (FIFO push), RXDATA, STATUS.
// Optional macro AXIL_STRB_EN: honour wstrb on CTRL and reject partial TXDATA writes.
module i2s2_axil_responder
  import i2s2_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int SAMPLE_W           = 24,
  parameter int TX_FIFO_DEPTH      = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [SAMPLE_W-1:0]             tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  input  logic [SAMPLE_W-1:0]             rx_data,
  input  logic                            rx_valid,
  output logic                            ctrl_enable
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int LW = $clog2(TX_FIFO_DEPTH) + 1;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic [DW-1:0]       ctrl_q, ctrl_wr_val, rd_word, status_word;
  logic                flush_q, ctrl_flush;
  logic                tx_ovf, rx_new, rx_ovf;
  logic [SAMPLE_W-1:0] rx_sample;

  logic                fifo_full, fifo_empty;
  logic [LW-1:0]       fifo_level;

  logic                wr_hs, rd_hs;
  logic [3:0]          wr_off, rd_off;
  logic                wr_ctrl, wr_tx, wr_status;
  logic                tx_strb_ok, tx_pop, tx_push, tx_ovf_set;
  logic [1:0]          wr_resp;
  logic                rx_clear, rx_ovf_set;
  logic                unused_inputs;

  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr, s_axi_wstrb};

  assign wr_hs  = s_axi_awready && s_axi_awvalid && s_axi_wvalid;
  assign rd_hs  = s_axi_arready && s_axi_arvalid;
  assign wr_off = {s_axi_awaddr[3:2], 2'b00};
  assign rd_off = {s_axi_araddr[3:2], 2'b00};

  assign wr_ctrl   = wr_hs && (wr_off == CTRL_OFF);
  assign wr_tx     = wr_hs && (wr_off == TXDATA_OFF);
  assign wr_status = wr_hs && (wr_off == STATUS_OFF);

`ifdef AXIL_STRB_EN
  assign tx_strb_ok = &s_axi_wstrb;
`else
  assign tx_strb_ok = 1'b1;
`endif

  // A pop on the handshake edge frees the slot the push needs, even when full.
  assign tx_pop     = tx_valid && tx_ready;
  assign tx_push    = wr_tx && tx_strb_ok && (!fifo_full || tx_pop);
  assign tx_ovf_set = wr_tx && tx_strb_ok && fifo_full && !tx_pop;
  assign wr_resp    = (wr_tx && !tx_push) ? RESP_SLVERR : RESP_OKAY;

  // Reading RXDATA consumes RX_NEW, so a simultaneous new sample is not an overflow.
  assign rx_clear   = rd_hs && (rd_off == RXDATA_OFF);
  assign rx_ovf_set = rx_valid && rx_new && !rx_clear;

  // NOTE: every combinational output is given a default first so no path
  // through the block can hold a stale value and infer a latch.
  always_comb begin
    ctrl_wr_val = ctrl_q;
`ifdef AXIL_STRB_EN
    for (int b = 0; b < DW/8; b++) begin
      if (s_axi_wstrb[b]) ctrl_wr_val[8*b +: 8] = s_axi_wdata[8*b +: 8];
    end
`else
    ctrl_wr_val = s_axi_wdata;
`endif
    ctrl_flush = ctrl_wr_val[CTRL_FLUSH_BIT];
    ctrl_wr_val[CTRL_FLUSH_BIT] = 1'b0;
  end

  always_comb begin
    status_word                           = '0;
    status_word[ST_RX_NEW]                = rx_new;
    status_word[ST_TX_FULL]               = fifo_full;
    status_word[ST_TX_EMPTY]              = fifo_empty;
    status_word[ST_TX_OVF]                = tx_ovf;
    status_word[ST_RX_OVF]                = rx_ovf;
    status_word[ST_LEVEL_LSB +: 8]        = 8'(fifo_level);
  end

  always_comb begin
    rd_word = '0;
    case (rd_off)
      CTRL_OFF:   rd_word = ctrl_q;
      RXDATA_OFF: rd_word = DW'(rx_sample);
      STATUS_OFF: rd_word = status_word;
      default:    rd_word = '0;
    endcase
  end

  assign ctrl_enable = ctrl_q[CTRL_EN_BIT];
  assign tx_valid    = !fifo_empty;

  // NOTE: clocked state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state      <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      ctrl_q        <= '0;
      flush_q       <= 1'b0;
      tx_ovf        <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      if (tx_ovf_set)                          tx_ovf <= 1'b1;
      else if (wr_status && s_axi_wdata[ST_TX_OVF]) tx_ovf <= 1'b0;

      case (wr_state)
        W_IDLE: begin
          if (wr_hs) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b1;
            s_axi_bresp   <= wr_resp;
            wr_state      <= W_RESP;
            if (wr_ctrl) begin
              ctrl_q  <= ctrl_wr_val;
              flush_q <= ctrl_flush;
            end
          end else if (s_axi_awvalid && s_axi_wvalid) begin
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            wr_state     <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state      <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (rd_hs) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rdata   <= rd_word;
            s_axi_rresp   <= RESP_OKAY;
            rd_state      <= R_DATA;
          end else if (s_axi_arvalid) begin
            s_axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            rd_state     <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rx_sample <= '0;
      rx_new    <= 1'b0;
      rx_ovf    <= 1'b0;
    end else begin
      if (rx_valid) rx_sample <= rx_data;
      if (rx_valid)      rx_new <= 1'b1;
      else if (rx_clear) rx_new <= 1'b0;
      if (rx_ovf_set)                               rx_ovf <= 1'b1;
      else if (wr_status && s_axi_wdata[ST_RX_OVF]) rx_ovf <= 1'b0;
    end
  end

  i2s2_sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (ACLK),
    .rst       (ARESET),
    .push      (tx_push),
    .push_data (s_axi_wdata[SAMPLE_W-1:0]),
    .pop       (tx_pop),
    .flush     (flush_q),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_i2s2_axil_responder.sv
// Directed self-checking bench for i2s2_axil_responder: register map, TX FIFO
// full/overflow/pop-on-push, RX new/overflow/collision, back-pressure and async reset.
module tb_i2s2_axil_responder;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [23:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [23:0] rx_data;
  logic        rx_valid;
  logic        ctrl_enable;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 ACLK = ~ACLK;

  i2s2_axil_responder dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .ctrl_enable   (ctrl_enable)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Full write transaction; optionally pops the TX FIFO exactly on the handshake edge.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic pop_at_hs,
                           output logic [1:0] resp, output logic b_now);
    logic seen;
    s_axi_awaddr  = addr;
    s_axi_wdata   = data;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge ACLK);
      if (s_axi_awready && s_axi_wready) seen = 1'b1;
    end
    if (!seen) check("aw_timeout", {31'b0, seen}, 32'h1);
    if (pop_at_hs) tx_ready = 1'b1;
    @(posedge ACLK); #1;
    tx_ready      = 1'b0;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    b_now = s_axi_bvalid;
    for (int n = 0; n < 20 && !s_axi_bvalid; n++) begin
      @(posedge ACLK); #1;
    end
    if (!s_axi_bvalid) check("b_timeout", {31'b0, s_axi_bvalid}, 32'h1);
    resp = s_axi_bresp;
    @(posedge ACLK); #1;
    s_axi_bready = 1'b0;
  endtask

  // Full read transaction; optionally strobes rx_valid exactly on the AR handshake edge.
  task automatic axi_read(input logic [3:0] addr, input logic rx_at_hs, input logic [23:0] rx_val,
                          output logic [31:0] data, output logic [1:0] resp);
    logic seen;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge ACLK);
      if (s_axi_arready) seen = 1'b1;
    end
    if (!seen) check("ar_timeout", {31'b0, seen}, 32'h1);
    if (rx_at_hs) begin
      rx_data  = rx_val;
      rx_valid = 1'b1;
    end
    @(posedge ACLK); #1;
    rx_valid      = 1'b0;
    s_axi_arvalid = 1'b0;
    for (int n = 0; n < 20 && !s_axi_rvalid; n++) begin
      @(posedge ACLK); #1;
    end
    if (!s_axi_rvalid) check("r_timeout", {31'b0, s_axi_rvalid}, 32'h1);
    data = s_axi_rdata;
    resp = s_axi_rresp;
    @(posedge ACLK); #1;
    s_axi_rready = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [3:0] addr, input logic [31:0] data,
                        input logic pop_at_hs, input logic [1:0] exp_resp);
    logic [1:0] resp;
    logic       b_now;
    axi_write(addr, data, pop_at_hs, resp, b_now);
    check({tag, "_bresp"}, {30'b0, resp}, {30'b0, exp_resp});
    check({tag, "_blat"}, {31'b0, b_now}, 32'h1);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] data;
    logic [1:0]  resp;
    axi_read(addr, 1'b0, 24'h0, data, resp);
    check(tag, data, exp);
    check({tag, "_rresp"}, {30'b0, resp}, 32'h0);
  endtask

  task automatic rx_pulse(input logic [23:0] val);
    rx_data  = val;
    rx_valid = 1'b1;
    @(posedge ACLK); #1;
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] data;
    logic [1:0]  resp;
    logic [23:0] exp_tx [4];

    ARESET = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_handshake", {26'b0, s_axi_awready, s_axi_wready, s_axi_bvalid,
                            s_axi_arready, s_axi_rvalid, tx_valid}, 32'h0);
    check("rst_resp_rdata", s_axi_rdata | {28'b0, s_axi_bresp, s_axi_rresp}, 32'h0);
    check("rst_enable", {31'b0, ctrl_enable}, 32'h0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    rd_chk("rst_ctrl", 4'h0, 32'h0);
    rd_chk("rst_txdata", 4'h4, 32'h0);
    rd_chk("rst_rxdata", 4'h8, 32'h0);
    rd_chk("rst_status", 4'hC, 32'h0000_0004);

    wr_chk("ctrl_en", 4'h0, 32'h1, 1'b0, 2'b00);
    check("ctrl_enable", {31'b0, ctrl_enable}, 32'h1);
    rd_chk("ctrl_rb", 4'h0, 32'h1);

    wr_chk("push_pre_flush", 4'h4, 32'h99, 1'b0, 2'b00);
    rd_chk("status_one", 4'hC, 32'h0000_0100);
    wr_chk("ctrl_flush", 4'h0, 32'h3, 1'b0, 2'b00);
    rd_chk("ctrl_after_flush", 4'h0, 32'h1);
    rd_chk("status_flushed", 4'hC, 32'h0000_0004);

    wr_chk("push11", 4'h4, 32'h11, 1'b0, 2'b00);
    wr_chk("push22", 4'h4, 32'h22, 1'b0, 2'b00);
    wr_chk("push33", 4'h4, 32'h33, 1'b0, 2'b00);
    wr_chk("push44", 4'h4, 32'h44, 1'b0, 2'b00);
    rd_chk("status_full", 4'hC, 32'h0000_0402);
    wr_chk("push55_full", 4'h4, 32'h55, 1'b0, 2'b10);
    rd_chk("status_ovf", 4'hC, 32'h0000_040A);
    wr_chk("push66_pop", 4'h4, 32'h66, 1'b1, 2'b00);
    rd_chk("status_pop_push", 4'hC, 32'h0000_040A);

    exp_tx[0] = 24'h22; exp_tx[1] = 24'h33; exp_tx[2] = 24'h44; exp_tx[3] = 24'h66;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tx_valid%0d", i), {31'b0, tx_valid}, 32'h1);
      check($sformatf("tx_data%0d", i), {8'b0, tx_data}, {8'b0, exp_tx[i]});
      @(posedge ACLK); #1;
    end
    tx_ready = 1'b0;
    check("tx_drained", {31'b0, tx_valid}, 32'h0);
    rd_chk("status_drained", 4'hC, 32'h0000_000C);
    wr_chk("w1c_txovf", 4'hC, 32'h8, 1'b0, 2'b00);
    rd_chk("status_txovf_clr", 4'hC, 32'h0000_0004);

    rx_pulse(24'hABCDEF);
    rd_chk("status_rxnew", 4'hC, 32'h0000_0005);
    rd_chk("rxdata", 4'h8, 32'h00AB_CDEF);
    rd_chk("status_rx_read", 4'hC, 32'h0000_0004);
    rx_pulse(24'h123456);
    @(posedge ACLK); #1;
    rx_pulse(24'h654321);
    rd_chk("status_rxovf", 4'hC, 32'h0000_0015);
    wr_chk("w1c_rxovf", 4'hC, 32'h10, 1'b0, 2'b00);
    rd_chk("status_rxovf_clr", 4'hC, 32'h0000_0005);

    axi_read(4'h8, 1'b1, 24'h0F0F0F, data, resp);
    check("rx_collide_old", data, 32'h0065_4321);
    rd_chk("status_collide", 4'hC, 32'h0000_0005);
    rd_chk("rxdata_new", 4'h8, 32'h000F_0F0F);

    s_axi_awaddr = 4'h0; s_axi_wdata = 32'h5; s_axi_wstrb = 4'hF;
    s_axi_araddr = 4'h8;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge ACLK);
        if (s_axi_awready && s_axi_arready) seen = 1'b1;
      end
      check("concurrent_hs", {31'b0, seen}, 32'h1);
    end
    @(posedge ACLK); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      check($sformatf("hold_flags%0d", i),
            {28'b0, s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_arready}, 32'hC);
      check($sformatf("hold_rdata%0d", i), s_axi_rdata, 32'h000F_0F0F);
    end
    check("hold_enable", {31'b0, ctrl_enable}, 32'h1);

    #2 ARESET = 1'b1;
    #1;
    check("async_abort", {30'b0, s_axi_bvalid, s_axi_rvalid}, 32'h0);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("post_rst_enable", {31'b0, ctrl_enable}, 32'h0);
    rd_chk("post_rst_ctrl", 4'h0, 32'h0);
    rd_chk("post_rst_status", 4'hC, 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
